adaptive_filter_mode_ctrl: RTL and testbench
============================================

// Module: adaptive_filter_mode_ctrl
// PURPOSE
//   Sequencer for the adaptive differentiator/integrator filter. Accepts mode-change requests
//   over a valid/ready handshake and drives the filter's mode select. Clears the filter's
//   delay line and feedback loop on every real switch, then blanks the output until the
//   pipeline has refilled. Enforces a minimum dwell time between switches and counts switches.
// PARAMETERS
//   DATA_WIDTH    14  width of filter output sample
//   FIR_ORDER     10  delay-line depth; cycles of output blanking after a clear
//   FLUSH_CYCLES   2  cycles filt_clear is held (covers 2-stage feedback loop)
//   MIN_DWELL     16  RUN cycles required before the next request is accepted (0 = none)
//   CNT_WIDTH     16  width of switch counter
// PORTS
//   clk         in   1           system clock
//   srst        in   1           synchronous reset, active-high
//   req_valid   in   1           mode-change request valid
//   req_mode    in   1           requested mode: 0 = differentiator, 1 = integrator
//   req_ready   out  1           request accepted on req_valid & req_ready
//   filt_mode   out  1           mode select to filter ctrl input
//   filt_clear  out  1           synchronous clear of filter delay line and feedback registers
//   filt_tdata  in   DATA_WIDTH  raw filter output
//   m_tdata     out  DATA_WIDTH  gated filter output
//   m_tvalid    out  1           m_tdata is a settled sample
//   busy        out  1           high in FLUSH or FILL
//   switch_cnt  out  CNT_WIDTH   number of real mode switches, saturating
// BEHAVIOUR
//   One clock; srst is synchronous and active-high. All outputs are registered.
//   Reset values: state=FILL, timer=FIR_ORDER-1, filt_mode=0, filt_clear=0, req_ready=0,
//     m_tdata=0, m_tvalid=0, busy=1, switch_cnt=0.
//   srst at any time, including mid-FLUSH/FILL, returns to the reset values on the next edge.
//   States:
//     FLUSH  filt_clear=1, m_tvalid=0; lasts FLUSH_CYCLES cycles; then FILL, timer=FIR_ORDER-1.
//     FILL   filt_clear=0, m_tvalid=0; lasts FIR_ORDER cycles; then RUN, dwell timer restarted.
//     RUN    m_tvalid=1, m_tdata<=filt_tdata (1-cycle latency); m_tdata=0 whenever m_tvalid=0.
//   req_ready=1 only in RUN after MIN_DWELL RUN cycles have elapsed; it is never high in FLUSH/FILL.
//   Accepted request, req_mode != filt_mode:
//     - filt_mode<=req_mode on the accept edge; state->FLUSH; switch_cnt+1, saturating at all-ones.
//   Accepted request, req_mode == filt_mode:
//     - no-op; state stays RUN, no clear, switch_cnt unchanged, dwell timer not restarted.
//   req_valid while req_ready=0: ignored and not stored; the requester holds it.
//   Acceptance edge T (real switch):
//     - filt_clear high cycles T+1..T+FLUSH_CYCLES.
//     - m_tvalid low from T+1; high again at T+1+FLUSH_CYCLES+FIR_ORDER.
//     - req_ready high again MIN_DWELL cycles after RUN re-entry.
//   A single down-counter serves flush, fill and dwell timing; it never wraps and holds at 0 in RUN.
//   busy = (state != RUN).
// STRUCTURE
//   adaptive_filter_pkg:
//     - typedef enum logic [1:0] {FLUSH, FILL, RUN} mode_ctrl_state_t.
//     - localparams MODE_DIFF=1'b0, MODE_INTEGR=1'b1.
//   Sub-module mode_ctrl_timer: loadable down-counter with load value, enable and zero flag.
//   The FSM, handshake, output gating and counter live in the top module.
// TESTING (defaults unless stated)
//   1 Reset release:
//     m_tvalid=0 for 10 cycles, then 1.
//     req_ready rises 16 cycles after m_tvalid.
//     switch_cnt=0.
//   2 req_mode=1 accepted at edge T:
//     filt_mode=1 from T+1.
//     filt_clear=1 at T+1,T+2 only.
//     m_tvalid=0 T+1..T+12, 1 at T+13.
//     switch_cnt=1.
//   3 req_mode=0 while filt_mode=0:
//     accepted in 1 cycle; filt_clear stays 0; m_tvalid stays 1.
//     switch_cnt unchanged; req_ready stays 1.
//   4 req_valid held from mid-FILL:
//     req_ready=0 until dwell expires; accepted on the first ready cycle only (single switch).
//   5 srst pulsed during FLUSH:
//     next cycle filt_mode=0, filt_clear=0, m_tvalid=0, switch_cnt=0; refill per test 1.
//   6 CNT_WIDTH=4, MIN_DWELL=0, 17 alternating switches:
//     switch_cnt=15 (saturated).
//     filter output sample 14'h1ABC in RUN appears on m_tdata one cycle later.

Source files
------------

// File: rtl/adaptive_filter_pkg.sv
// Shared types and constants for the adaptive differentiator/integrator filter
// mode controller.
//   mode_ctrl_state_t : sequencer state (FLUSH, FILL, RUN)
//   MODE_DIFF/INTEGR  : encodings of the filter mode select
//   max3              : helper used to size the shared timer
package adaptive_filter_pkg;

  typedef enum logic [1:0] {FLUSH, FILL, RUN} mode_ctrl_state_t;

  localparam logic MODE_DIFF   = 1'b0;
  localparam logic MODE_INTEGR = 1'b1;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/mode_ctrl_timer.sv
// Loadable down-counter shared by the flush, fill and dwell phases.
// Ports:
//   clk, srst  : clock, synchronous active-high reset (loads RST_VAL)
//   load       : load load_val on the next edge (priority over en)
//   load_val   : value to load
//   en         : count down when set; the counter holds at zero and never wraps
//   count      : current value
//   zero       : count == 0
module mode_ctrl_timer #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (srst) begin
      count <= WIDTH'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/adaptive_filter_mode_ctrl.sv
// Sequencer for the adaptive differentiator/integrator filter.
// Accepts mode-change requests over valid/ready, drives the filter mode select,
// clears the filter on every real switch, blanks the output until the delay line
// has refilled, enforces a minimum dwell between switches and counts switches.
// Ports:
//   clk, srst   : clock, synchronous active-high reset
//   req_valid   : mode-change request valid
//   req_mode    : requested mode (0 = differentiator, 1 = integrator)
//   req_ready   : request accepted on req_valid & req_ready
//   filt_mode   : mode select to the filter
//   filt_clear  : clear of filter delay line and feedback registers
//   filt_tdata  : raw filter output
//   m_tdata     : gated filter output (0 while m_tvalid is low)
//   m_tvalid    : m_tdata is a settled sample
//   busy        : high in FLUSH or FILL
//   switch_cnt  : number of real mode switches, saturating
module adaptive_filter_mode_ctrl
  import adaptive_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 14,
  parameter int unsigned FIR_ORDER    = 10,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MIN_DWELL    = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  req_valid,
  input  logic                  req_mode,
  output logic                  req_ready,
  output logic                  filt_mode,
  output logic                  filt_clear,
  input  logic [DATA_WIDTH-1:0] filt_tdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  switch_cnt
);

  localparam int unsigned TMAX = max3(FIR_ORDER - 1, FLUSH_CYCLES - 1, MIN_DWELL);
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  mode_ctrl_state_t state;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_count;
  logic          tmr_zero;
  logic          do_switch;

  mode_ctrl_timer #(
    .WIDTH   (TW),
    .RST_VAL (FIR_ORDER - 1)
  ) u_timer (
    .clk      (clk),
    .srst     (srst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (1'b1),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // Timer reloads happen on the same edge as the state transition they time.
  always_comb begin
    do_switch = (state == RUN) && req_valid && req_ready && (req_mode != filt_mode);
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state)
      FLUSH: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(FIR_ORDER - 1);
      end
      FILL: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(MIN_DWELL);
      end
      RUN: if (do_switch) begin
        tmr_load = 1'b1;
        tmr_val  = TW'(FLUSH_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state      <= FILL;
      filt_mode  <= MODE_DIFF;
      filt_clear <= 1'b0;
      req_ready  <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      busy       <= 1'b1;
      switch_cnt <= '0;
    end else begin
      case (state)
        FLUSH: begin
          if (tmr_zero) begin
            state      <= FILL;
            filt_clear <= 1'b0;
          end
        end
        FILL: begin
          if (tmr_zero) begin
            state     <= RUN;
            busy      <= 1'b0;
            m_tvalid  <= 1'b1;
            m_tdata   <= filt_tdata;
            req_ready <= (MIN_DWELL == 0);
          end
        end
        RUN: begin
          if (do_switch) begin
            state      <= FLUSH;
            filt_mode  <= req_mode;
            filt_clear <= 1'b1;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            if (switch_cnt != '1) switch_cnt <= switch_cnt + CNT_WIDTH'(1);
          end else begin
            m_tdata   <= filt_tdata;
            // Ready is registered, so raise it on the edge where the dwell count reaches zero.
            req_ready <= tmr_zero || (tmr_count == TW'(1));
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_adaptive_filter_mode_ctrl.sv
module tb_adaptive_filter_mode_ctrl;

  logic        clk;
  logic        srst;
  logic        req_valid, req_mode;
  logic        req_ready, filt_mode, filt_clear, m_tvalid, busy;
  logic [13:0] filt_tdata, m_tdata;
  logic [15:0] switch_cnt;

  logic        req_valid2, req_mode2;
  logic        req_ready2, filt_mode2, filt_clear2, m_tvalid2, busy2;
  logic [13:0] m_tdata2;
  logic [3:0]  switch_cnt2;

  int total = 0;
  int bad   = 0;

  adaptive_filter_mode_ctrl u_dut (
    .clk        (clk),
    .srst       (srst),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .filt_mode  (filt_mode),
    .filt_clear (filt_clear),
    .filt_tdata (filt_tdata),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .busy       (busy),
    .switch_cnt (switch_cnt)
  );

  adaptive_filter_mode_ctrl #(
    .CNT_WIDTH (4),
    .MIN_DWELL (0)
  ) u_sat (
    .clk        (clk),
    .srst       (srst),
    .req_valid  (req_valid2),
    .req_mode   (req_mode2),
    .req_ready  (req_ready2),
    .filt_mode  (filt_mode2),
    .filt_clear (filt_clear2),
    .filt_tdata (filt_tdata),
    .m_tdata    (m_tdata2),
    .m_tvalid   (m_tvalid2),
    .busy       (busy2),
    .switch_cnt (switch_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clear;
    logic        valid;
    logic        bsy;
    logic [13:0] data;
  } trace_t;

  typedef struct {
    logic [13:0] din;
    logic [13:0] exp_dout;
  } dvec_t;

  trace_t trace [13];
  dvec_t  dtab  [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    logic       mexp;
    logic [3:0] cexp;

    // Cycle-by-cycle trace after a real switch at edge T; entry i sampled after edge T+i.
    trace = '{
      '{1'b1, 1'b0, 1'b1, 14'h0000},
      '{1'b1, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b0, 1'b1, 14'h0000},
      '{1'b0, 1'b1, 1'b0, 14'h0123}
    };
    dtab = '{
      '{14'h0000, 14'h0000},
      '{14'h3FFF, 14'h3FFF},
      '{14'h1ABC, 14'h1ABC},
      '{14'h2AAA, 14'h2AAA},
      '{14'h0001, 14'h0001}
    };

    srst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; filt_tdata = 14'h0555;
    req_valid2 = 1'b0; req_mode2 = 1'b0;

    // Test 1: reset values and refill after release
    step();
    srst = 1'b0;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_busy", busy, 1);
    check("rst_clear", filt_clear, 0);
    check("rst_mode", filt_mode, 0);
    check("rst_ready", req_ready, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_cnt", switch_cnt, 0);
    n = 0;
    while (!m_tvalid && n < 50) begin step(); n++; end
    check("rst_fill_len", n, 10);
    check("rst_tdata_run", m_tdata, 14'h0555);
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("rst_dwell_len", n, 16);
    check("rst_cnt_after", switch_cnt, 0);

    // Test 3: same-mode request is a no-op
    req_valid = 1'b1; req_mode = 1'b0;
    step();
    req_valid = 1'b0;
    check("noop_clear", filt_clear, 0);
    check("noop_tvalid", m_tvalid, 1);
    check("noop_cnt", switch_cnt, 0);
    check("noop_ready", req_ready, 1);
    step();
    check("noop_ready2", req_ready, 1);
    check("noop_busy", busy, 0);

    // RUN pass-through with one cycle of latency
    for (int i = 0; i < 5; i++) begin
      filt_tdata = dtab[i].din;
      step();
      check("run_tdata", m_tdata, dtab[i].exp_dout);
      check("run_tvalid", m_tvalid, 1);
    end

    // Test 2: switch to integrator at edge T
    filt_tdata = 14'h0123;
    req_valid = 1'b1; req_mode = 1'b1;
    step();
    req_valid = 1'b0;
    check("sw_mode", filt_mode, 1);
    check("sw_cnt", switch_cnt, 1);
    for (int i = 0; i < 13; i++) begin
      if (i != 0) step();
      check("sw_clear", filt_clear, trace[i].clear);
      check("sw_tvalid", m_tvalid, trace[i].valid);
      check("sw_busy", busy, trace[i].bsy);
      check("sw_tdata", m_tdata, trace[i].data);
      check("sw_ready", req_ready, 0);
    end
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("sw_dwell_len", n, 16);

    // Switch back to differentiator, then test 4: request held from mid-FILL
    req_valid = 1'b1; req_mode = 1'b0;
    step();
    req_valid = 1'b0;
    check("back_mode", filt_mode, 0);
    check("back_clear", filt_clear, 1);
    check("back_cnt", switch_cnt, 2);
    for (int i = 0; i < 5; i++) step();
    req_valid = 1'b1; req_mode = 1'b1;
    n = 0;
    while (!req_ready && n < 60) begin
      check("held_ready_busy", req_ready & busy, 0);
      step(); n++;
    end
    check("held_wait_len", n, 23);
    step();
    req_valid = 1'b0;
    check("held_mode", filt_mode, 1);
    check("held_clear", filt_clear, 1);
    check("held_cnt", switch_cnt, 3);
    check("held_ready", req_ready, 0);

    // Test 5: srst during FLUSH
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("flrst_mode", filt_mode, 0);
    check("flrst_clear", filt_clear, 0);
    check("flrst_tvalid", m_tvalid, 0);
    check("flrst_cnt", switch_cnt, 0);
    check("flrst_busy", busy, 1);
    n = 0;
    while (!m_tvalid && n < 50) begin step(); n++; end
    check("flrst_fill_len", n, 10);
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("flrst_dwell_len", n, 16);

    // Test 6: saturating counter, MIN_DWELL=0
    mexp = 1'b0;
    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (!req_ready2 && n < 100) begin step(); n++; end
      check("sat_ready_seen", req_ready2, 1);
      check("sat_ready_tvalid", m_tvalid2, 1);
      mexp = ~mexp;
      cexp = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      req_valid2 = 1'b1; req_mode2 = mexp;
      step();
      req_valid2 = 1'b0;
      check("sat_mode", filt_mode2, mexp);
      check("sat_cnt", switch_cnt2, cexp);
    end
    check("sat_final", switch_cnt2, 15);
    n = 0;
    while (!m_tvalid2 && n < 50) begin step(); n++; end
    check("sat_fill_len", n, 12);
    check("sat_ready_at_run", req_ready2, 1);
    filt_tdata = 14'h1ABC;
    step();
    check("sat_tdata", m_tdata2, 14'h1ABC);
    filt_tdata = 14'h0000;
    step();
    check("sat_tdata0", m_tdata2, 14'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
